// File: rtl/akuma_motion_ctrl_if.sv
// Player-input and sprite-origin bundle between the input decoder, the Akuma
// motion controller and the sprite renderers.
interface akuma_motion_ctrl_if;
    logic       frame_start;
    logic       key_left;
    logic       key_right;
    logic       key_jump;
    logic [9:0] AkumaX;
    logic [9:0] AkumaY;
    logic       facing_left;
    logic [1:0] motion_state;
    logic       airborne;

    modport master (
        output frame_start, key_left, key_right, key_jump,
        input  AkumaX, AkumaY, facing_left, motion_state, airborne
    );

    modport slave (
        input  frame_start, key_left, key_right, key_jump,
        output AkumaX, AkumaY, facing_left, motion_state, airborne
    );
endinterface

// File: rtl/akuma_motion_ctrl.sv
// Per-frame ground/air motion controller for the Akuma sprite: walking, jumping
// with gravity, landing recovery; origin only moves on frame_start.
module akuma_motion_ctrl #(
    parameter int START_X     = 100,
    parameter int GROUND_Y    = 240,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 498,
    parameter int WALK_STEP   = 3,
    parameter int JUMP_V0     = 12,
    parameter int GRAVITY     = 1,
    parameter int LAND_FRAMES = 4
) (
    input logic                vga_clk,
    input logic                Reset,
    akuma_motion_ctrl_if.slave mc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_AIR  = 2'd2,
        ST_LAND = 2'd3
    } state_e;

    localparam logic signed [10:0] X_MIN_S    = 11'(X_MIN);
    localparam logic signed [10:0] X_MAX_S    = 11'(X_MAX);
    localparam logic signed [10:0] GROUND_S   = 11'(GROUND_Y);
    localparam logic signed [3:0]  STEP_S     = 4'(WALK_STEP);
    localparam logic signed [5:0]  GRAV_S     = 6'(GRAVITY);
    localparam logic signed [5:0]  TAKEOFF_VY = 6'(GRAVITY - JUMP_V0);
    localparam logic [9:0]         TAKEOFF_Y  = 10'(GROUND_Y - JUMP_V0);
    localparam logic [3:0]         LAND_INIT  = 4'(LAND_FRAMES - 1);

    state_e             state_q, state_d;
    logic [9:0]         x_q, x_d;
    logic [9:0]         y_q, y_d;
    logic signed [5:0]  vy_q, vy_d;
    logic signed [3:0]  dx_q, dx_d;
    logic [3:0]         land_cnt_q, land_cnt_d;
    logic               facing_q, facing_d;
    logic               airborne_q;

    logic               left_only, right_only;
    logic signed [3:0]  step;
    logic signed [10:0] y_sum;

    // Wide signed add so both a step below X_MIN and past X_MAX are caught.
    function automatic logic [9:0] clamp_x(input logic [9:0] x, input logic signed [3:0] dx);
        logic signed [10:0] sum;
        sum = $signed({1'b0, x}) + $signed({{7{dx[3]}}, dx});
        if (sum < X_MIN_S)
            return X_MIN_S[9:0];
        else if (sum > X_MAX_S)
            return X_MAX_S[9:0];
        else
            return sum[9:0];
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        vy_d       = vy_q;
        dx_d       = dx_q;
        land_cnt_d = land_cnt_q;
        facing_d   = facing_q;

        left_only  = mc.key_left & ~mc.key_right;
        right_only = mc.key_right & ~mc.key_left;
        step       = '0;
        if (left_only)
            step = -STEP_S;
        else if (right_only)
            step = STEP_S;

        y_sum = $signed({1'b0, y_q}) + $signed({{5{vy_q[5]}}, vy_q});

        if (mc.frame_start) begin
            unique case (state_q)
                ST_IDLE, ST_WALK: begin
                    if (mc.key_jump) begin
                        state_d = ST_AIR;
                        dx_d    = step;
                        x_d     = clamp_x(x_q, step);
                        y_d     = TAKEOFF_Y;
                        vy_d    = TAKEOFF_VY;
                        if (left_only | right_only)
                            facing_d = left_only;
                    end else if (left_only | right_only) begin
                        state_d  = ST_WALK;
                        x_d      = clamp_x(x_q, step);
                        facing_d = left_only;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_AIR: begin
                    // Horizontal drift was latched at takeoff; keys are ignored.
                    x_d = clamp_x(x_q, dx_q);
                    if (y_sum >= GROUND_S) begin
                        y_d        = GROUND_S[9:0];
                        vy_d       = '0;
                        land_cnt_d = LAND_INIT;
                        state_d    = ST_LAND;
                    end else begin
                        y_d  = (y_sum < 11'sd0) ? 10'd0 : y_sum[9:0];
                        vy_d = vy_q + GRAV_S;
                    end
                end
                ST_LAND: begin
                    if (land_cnt_q == 4'd0)
                        state_d = ST_IDLE;
                    else
                        land_cnt_d = land_cnt_q - 4'd1;
                end
            endcase
        end
    end

    always_ff @(posedge vga_clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (Reset) begin
            state_q    <= ST_IDLE;
            x_q        <= 10'(START_X);
            y_q        <= 10'(GROUND_Y);
            vy_q       <= '0;
            dx_q       <= '0;
            land_cnt_q <= '0;
            facing_q   <= 1'b0;
            airborne_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            vy_q       <= vy_d;
            dx_q       <= dx_d;
            land_cnt_q <= land_cnt_d;
            facing_q   <= facing_d;
            airborne_q <= (state_d == ST_AIR);
        end
    end

    assign mc.AkumaX       = x_q;
    assign mc.AkumaY       = y_q;
    assign mc.facing_left  = facing_q;
    assign mc.motion_state = state_q;
    assign mc.airborne     = airborne_q;

endmodule

// File: tb/tb_akuma_motion_ctrl.sv
// Self-checking bench for akuma_motion_ctrl: directed walk/clamp/jump/reset
// scenarios plus randomized frames against an integer reference model.
module tb_akuma_motion_ctrl;

    localparam int START_X     = 100;
    localparam int GROUND_Y    = 240;
    localparam int X_MIN       = 0;
    localparam int X_MAX       = 498;
    localparam int WALK_STEP   = 3;
    localparam int JUMP_V0     = 12;
    localparam int GRAVITY     = 1;
    localparam int LAND_FRAMES = 4;

    logic vga_clk = 1'b0;
    logic Reset;

    akuma_motion_ctrl_if bus ();

    akuma_motion_ctrl dut (
        .vga_clk (vga_clk),
        .Reset   (Reset),
        .mc      (bus.slave)
    );

    always #5 vga_clk = ~vga_clk;

    int errors = 0;
    int checks = 0;

    // Reference model state, in plain integers.
    int m_x, m_y, m_vy, m_dx, m_cnt, m_mode;
    bit m_face;

    int jump_y [25] = '{228, 217, 207, 198, 190, 183, 177, 172, 168, 165, 163, 162,
                        162, 163, 165, 168, 172, 177, 183, 190, 198, 207, 217, 228, 240};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int clampx(input int v);
        if (v < X_MIN) return X_MIN;
        if (v > X_MAX) return X_MAX;
        return v;
    endfunction

    function automatic void model_reset();
        m_x = START_X; m_y = GROUND_Y; m_vy = 0; m_dx = 0; m_cnt = 0; m_mode = 0; m_face = 1'b0;
    endfunction

    function automatic void model_frame(input bit l, input bit r, input bit j);
        int dir;
        dir = (l && !r) ? -1 : ((r && !l) ? 1 : 0);
        case (m_mode)
            0, 1: begin
                if (j) begin
                    m_mode = 2;
                    m_dx   = dir * WALK_STEP;
                    m_x    = clampx(m_x + m_dx);
                    m_y    = GROUND_Y - JUMP_V0;
                    m_vy   = -JUMP_V0 + GRAVITY;
                    if (dir != 0) m_face = (dir < 0);
                end else if (dir != 0) begin
                    m_mode = 1;
                    m_x    = clampx(m_x + dir * WALK_STEP);
                    m_face = (dir < 0);
                end else begin
                    m_mode = 0;
                end
            end
            2: begin
                m_x = clampx(m_x + m_dx);
                if (m_y + m_vy >= GROUND_Y) begin
                    m_y = GROUND_Y; m_vy = 0; m_cnt = LAND_FRAMES - 1; m_mode = 3;
                end else begin
                    m_y  = (m_y + m_vy < 0) ? 0 : m_y + m_vy;
                    m_vy = m_vy + GRAVITY;
                end
            end
            default: begin
                if (m_cnt == 0) m_mode = 0;
                else m_cnt--;
            end
        endcase
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_x"},    32'(bus.AkumaX),       32'(m_x));
        check({tag, "_y"},    32'(bus.AkumaY),       32'(m_y));
        check({tag, "_face"}, 32'(bus.facing_left),  32'(m_face));
        check({tag, "_st"},   32'(bus.motion_state), 32'(m_mode));
        check({tag, "_air"},  32'(bus.airborne),     32'(m_mode == 2));
    endtask

    // One strobe with the given keys, then 0..2 idle cycles with noise on the keys.
    task automatic do_frame(input bit l, input bit r, input bit j);
        int gaps;
        @(negedge vga_clk);
        bus.key_left = l; bus.key_right = r; bus.key_jump = j;
        bus.frame_start = 1'b1;
        @(negedge vga_clk);
        bus.frame_start = 1'b0;
        model_frame(l, r, j);
        check_all("frame");
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) begin
            bus.key_left  = 1'($urandom);
            bus.key_right = 1'($urandom);
            bus.key_jump  = 1'($urandom);
            @(negedge vga_clk);
            check_all("hold");
        end
    endtask

    task automatic do_reset(input bit with_strobe);
        @(negedge vga_clk);
        Reset = 1'b1;
        bus.frame_start = with_strobe;
        bus.key_left  = 1'($urandom);
        bus.key_right = 1'($urandom);
        bus.key_jump  = 1'($urandom);
        @(negedge vga_clk);
        Reset = 1'b0;
        bus.frame_start = 1'b0;
        bus.key_left = 1'b0; bus.key_right = 1'b0; bus.key_jump = 1'b0;
        model_reset();
        check_all("reset");
    endtask

    initial begin
        Reset = 1'b1;
        bus.frame_start = 1'b0;
        bus.key_left = 1'b0; bus.key_right = 1'b0; bus.key_jump = 1'b0;
        model_reset();
        repeat (2) @(negedge vga_clk);

        // Reset state and idle frames.
        do_reset(1'b0);
        check("rst_x", 32'(bus.AkumaX), 32'd100);
        check("rst_y", 32'(bus.AkumaY), 32'd240);
        repeat (3) do_frame(1'b0, 1'b0, 1'b0);

        // Walking right, one step left, then both keys.
        for (int k = 1; k <= 5; k++) begin
            do_frame(1'b0, 1'b1, 1'b0);
            check("walk_r_x", 32'(bus.AkumaX), 32'(100 + 3 * k));
        end
        do_frame(1'b1, 1'b0, 1'b0);
        check("walk_l_x",    32'(bus.AkumaX),       32'd112);
        check("walk_l_face", 32'(bus.facing_left),  32'd1);
        check("walk_l_st",   32'(bus.motion_state), 32'd1);
        do_frame(1'b1, 1'b1, 1'b0);
        check("both_st", 32'(bus.motion_state), 32'd0);
        check("both_x",  32'(bus.AkumaX),       32'd112);

        // Left clamp at X_MIN.
        repeat (36) do_frame(1'b1, 1'b0, 1'b0);
        check("clamp_l4", 32'(bus.AkumaX), 32'd4);
        do_frame(1'b1, 1'b0, 1'b0);
        check("clamp_l1", 32'(bus.AkumaX), 32'd1);
        do_frame(1'b1, 1'b0, 1'b0);
        check("clamp_l0", 32'(bus.AkumaX), 32'd0);
        do_frame(1'b1, 1'b0, 1'b0);
        check("clamp_l0b", 32'(bus.AkumaX), 32'd0);

        // Right clamp at X_MAX.
        do_reset(1'b0);
        repeat (132) do_frame(1'b0, 1'b1, 1'b0);
        check("clamp_r496", 32'(bus.AkumaX), 32'd496);
        do_frame(1'b0, 1'b1, 1'b0);
        check("clamp_r498", 32'(bus.AkumaX), 32'd498);
        do_frame(1'b0, 1'b1, 1'b0);
        check("clamp_r498b", 32'(bus.AkumaX), 32'd498);

        // Vertical jump trajectory and landing recovery.
        do_reset(1'b0);
        for (int k = 0; k < 25; k++) begin
            do_frame(1'b0, 1'b0, 1'b1);
            check("jump_y",   32'(bus.AkumaY),       32'(jump_y[k]));
            check("jump_air", 32'(bus.airborne),     32'(k < 24));
            check("jump_st",  32'(bus.motion_state), (k < 24) ? 32'd2 : 32'd3);
        end
        for (int k = 0; k < 4; k++) begin
            do_frame(1'($urandom), 1'($urandom), 1'($urandom));
            check("land_st", 32'(bus.motion_state), (k < 3) ? 32'd3 : 32'd0);
            check("land_y",  32'(bus.AkumaY),       32'd240);
        end

        // Jump with drift to the right; mid-air keys have no effect.
        do_reset(1'b0);
        do_frame(1'b0, 1'b1, 1'b1);
        repeat (24) do_frame(1'($urandom), 1'($urandom), 1'($urandom));
        check("drift_x",    32'(bus.AkumaX),       32'd175);
        check("drift_face", 32'(bus.facing_left),  32'd0);
        check("drift_st",   32'(bus.motion_state), 32'd3);

        // Reset coinciding with a strobe mid-jump.
        do_reset(1'b0);
        repeat (5) do_frame(1'b0, 1'b0, 1'b1);
        check("midjump_y", 32'(bus.AkumaY), 32'd190);
        do_reset(1'b1);
        check("mrst_x",   32'(bus.AkumaX),       32'd100);
        check("mrst_y",   32'(bus.AkumaY),       32'd240);
        check("mrst_st",  32'(bus.motion_state), 32'd0);
        check("mrst_air", 32'(bus.airborne),     32'd0);
        do_frame(1'b0, 1'b0, 1'b0);
        check("post_x",  32'(bus.AkumaX),       32'd100);
        check("post_y",  32'(bus.AkumaY),       32'd240);
        check("post_st", 32'(bus.motion_state), 32'd0);

        // Randomized play against the reference model.
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 63) == 0)
                do_reset(1'($urandom));
            else
                do_frame(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/akuma_motion_ctrl.md
Name: akuma_motion_ctrl

Overview:
Per-frame motion and state controller for the Akuma character. It consumes decoded player inputs and a one-cycle frame strobe, and runs a ground/air state machine with horizontal clamping and gravity. It produces the registered sprite origin (AkumaX, AkumaY) and the facing select that drive the left/right sprite renderers directly downstream. Position changes only once per frame, so the renderer always sees a stable origin while drawing.

Parameters:
START_X, 100, X origin after reset
GROUND_Y, 240, Y origin when standing (480 - sprite height 240)
X_MIN, 0, leftmost legal AkumaX
X_MAX, 498, rightmost legal AkumaX (640 - sprite width 142)
WALK_STEP, 3, pixels per frame when walking or drifting in air
JUMP_V0, 12, takeoff upward speed in pixels/frame
GRAVITY, 1, per-frame added to vertical velocity
LAND_FRAMES, 4, frames of landing recovery during which input is ignored

Ports:
vga_clk  input  1  pixel clock; sole clock
Reset  input  1  synchronous, active-high reset
frame_start  input  1  one-cycle pulse at start of vertical blank
key_left  input  1  level, left held
key_right  input  1  level, right held
key_jump  input  1  level, jump held
AkumaX  output  10  sprite origin X
AkumaY  output  10  sprite origin Y
facing_left  output  1  1 = select left-facing sprite
motion_state  output  2  0 IDLE, 1 WALK, 2 AIR, 3 LAND
airborne  output  1  1 while motion_state == AIR

Behaviour:
- Reset, sampled on the vga_clk rising edge when Reset=1, has priority over everything. It sets AkumaX=START_X, AkumaY=GROUND_Y, facing_left=0, state=IDLE, vy=0, air_dx=0 and land_cnt=0. This applies mid-jump as well. A frame_start coinciding with Reset is discarded.
- All state updates occur only on cycles with frame_start=1. Outputs are registered and become valid on the edge that samples frame_start, so latency is 1 cycle. Between strobes all outputs hold.
- Horizontal direction: dir = -1 if key_left & ~key_right; +1 if key_right & ~key_left; 0 otherwise (both pressed or neither).
- IDLE/WALK (grounded):
  - If key_jump=1: state becomes AIR. air_dx = dir*WALK_STEP is latched. Y becomes GROUND_Y - JUMP_V0. vy becomes -JUMP_V0 + GRAVITY. X += air_dx with clamping.
  - Otherwise, if dir != 0: state WALK, X += dir*WALK_STEP clamped, facing_left = (dir == -1).
  - Otherwise: state IDLE.
  - Jump has priority over walk. Facing also updates on the takeoff frame when dir != 0.
- AIR:
  - Keys are ignored. facing_left is frozen.
  - X += air_dx, clamped.
  - If Y + vy >= GROUND_Y: Y = GROUND_Y, vy = 0, land_cnt = LAND_FRAMES - 1, state LAND.
  - Otherwise: Y += vy and vy += GRAVITY.
- LAND:
  - Input is ignored and position holds.
  - If land_cnt == 0 the state goes to IDLE. Otherwise land_cnt decrements.
  - Total time in LAND is LAND_FRAMES frames.
- Arithmetic:
  - X and Y are computed in signed 11 bits. vy is signed 6 bits.
  - Clamp X to [X_MIN, X_MAX] after every add, covering both underflow below 0 and overflow past X_MAX.
  - Y never exceeds GROUND_Y and never goes below 0; clamp at 0.
- airborne is a decode of state == AIR and is registered with it.

Test Plan:
- Reset, then hold idle for 3 frames -> AkumaX=100, AkumaY=240, facing_left=0, motion_state=0 throughout; no output change between frame_start pulses.
- key_right for 5 frames -> AkumaX 103,106,109,112,115, one cycle after each strobe. Then key_left for 1 frame -> AkumaX=112, facing_left=1, state WALK. Both keys held -> state IDLE, X holds.
- Walk left from X=4 -> X=1 then 0 (clamped) and stays 0. From X=497, walking right -> 498 and stays there.
- key_jump from ground at X=100 with no direction:
  - AkumaY after frames 1..12: 228, 217, 207, ... ending at 162.
  - Frame 13 -> 162. Frame 24 -> 228. Frame 25 -> 240 with state LAND.
  - State stays LAND for 4 frames, keys ignored, then IDLE.
  - airborne=1 for exactly 24 strobes (frames 1..24).
- Jump with key_right held at X=100 -> X advances by 3 per frame for 25 frames to 175. Releasing or reversing keys mid-air has no effect; facing_left stays 0.
- Reset asserted on the same cycle as frame_start mid-jump (Y=190) -> next cycle X=100, Y=240, state IDLE, airborne=0. The following frame_start with no keys -> unchanged.
